// File: rtl/aes_host_driver.sv
// Host-side sequencer for a pipelined AES engine: key load/priming, job issue with
// in-flight accounting, and an in-order response FIFO with overflow flag.
package aes_host_pkg;
   typedef enum logic [1:0] {INVALID = 2'd0, ENCRYPT = 2'd1, DECRYPT = 2'd2} job_t;
endpackage

module aes_host_driver
   import aes_host_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int WARM_CYCLES = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   input  logic         req_valid,
   output logic         req_ready,
   input  job_t         req_type,
   input  logic [127:0] req_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output job_t         rsp_type,
   output logic [127:0] rsp_data,
   output job_t         eng_in_type,
   output logic         eng_set_key,
   output logic         eng_halt,
   output logic [127:0] eng_state,
   output logic [127:0] eng_key,
   input  logic [127:0] eng_out,
   input  job_t         eng_out_type,
   output logic         busy,
   output logic         err_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = (WARM_CYCLES > 2) ? $clog2(WARM_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, PRIME, WARM, RUN, DRAIN, HALT} state_t;

   state_t          state_q, state_d;
   logic [127:0]    key_q, key_d;
   logic [4:0]      inflight_q, inflight_d;
   logic            discard_pend_q, discard_pend_d;
   logic [WW-1:0]   warm_cnt_q, warm_cnt_d;
   job_t            eng_in_type_q, eng_in_type_d;
   logic [127:0]    eng_state_q, eng_state_d;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   fifo_count_q;
   logic            err_overflow_q;
   logic [129:0]    mem_q [FIFO_DEPTH];

   logic            key_hs, req_hs, issue, inflight_inc, inflight_dec;
   logic            res_valid, discard, push, pop, push_ok, overflow;
   logic            fifo_full, fifo_empty;
   logic [31:0]     occupancy;
   logic [129:0]    head;

   assign fifo_full  = (fifo_count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_count_q == '0);
   assign occupancy  = 32'(fifo_count_q) + 32'(inflight_q);

   assign key_ready  = !rst && (state_q == IDLE || state_q == RUN);
   assign req_ready  = (state_q == RUN) && !key_valid && (occupancy < 32'(FIFO_DEPTH));
   assign key_hs     = key_valid && key_ready;
   assign req_hs     = req_valid && req_ready;
   assign issue      = req_hs && (req_type != INVALID);

   // Results only count while something is outstanding, so stale engine output
   // left over from before a reset is ignored.
   assign res_valid  = (eng_out_type != INVALID) && (inflight_q != 5'd0);
   assign discard    = res_valid && discard_pend_q;
   assign push       = res_valid && !discard_pend_q;
   assign pop        = !fifo_empty && rsp_ready;
   assign push_ok    = push && (!fifo_full || pop);
   assign overflow   = push && fifo_full && !pop;

   assign inflight_inc = issue || (state_q == PRIME);
   assign inflight_dec = res_valid;

   always_comb begin
      state_d        = state_q;
      key_d          = key_q;
      warm_cnt_d     = warm_cnt_q;
      eng_in_type_d  = INVALID;
      eng_state_d    = '0;
      discard_pend_d = discard_pend_q;
      inflight_d     = inflight_q;

      case ({inflight_inc, inflight_dec})
         2'b10:   inflight_d = inflight_q + 5'd1;
         2'b01:   inflight_d = inflight_q - 5'd1;
         default: inflight_d = inflight_q;
      endcase

      if (discard) discard_pend_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (key_hs) begin
               key_d   = key_in;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // Dummy all-zero encrypt lands on the engine during PRIME.
            state_d       = PRIME;
            eng_in_type_d = ENCRYPT;
         end
         PRIME: begin
            state_d        = WARM;
            warm_cnt_d     = '0;
            discard_pend_d = 1'b1;
         end
         WARM: begin
            if (warm_cnt_q == WW'(WARM_CYCLES - 1)) begin
               state_d    = RUN;
               warm_cnt_d = '0;
            end else begin
               warm_cnt_d = warm_cnt_q + WW'(1);
            end
         end
         RUN: begin
            if (key_hs) begin
               key_d   = key_in;
               state_d = DRAIN;
            end else if (issue) begin
               eng_in_type_d = req_type;
               eng_state_d   = req_data;
            end
         end
         DRAIN: begin
            if (inflight_q == 5'd0 && !discard_pend_q) state_d = HALT;
         end
         HALT:    state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         key_q          <= '0;
         inflight_q     <= '0;
         discard_pend_q <= 1'b0;
         warm_cnt_q     <= '0;
         eng_in_type_q  <= INVALID;
         eng_state_q    <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         fifo_count_q   <= '0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         key_q          <= key_d;
         inflight_q     <= inflight_d;
         discard_pend_q <= discard_pend_d;
         warm_cnt_q     <= warm_cnt_d;
         eng_in_type_q  <= eng_in_type_d;
         eng_state_q    <= eng_state_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
            2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
            default: fifo_count_q <= fifo_count_q;
         endcase
         if (overflow) err_overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {eng_out_type, eng_out};
   end

   assign head         = mem_q[rd_ptr_q];
   assign rsp_valid    = !fifo_empty;
   assign rsp_type     = fifo_empty ? INVALID : job_t'(head[129:128]);
   assign rsp_data     = fifo_empty ? '0 : head[127:0];

   assign eng_in_type  = eng_in_type_q;
   assign eng_state    = eng_state_q;
   assign eng_set_key  = (state_q == LOAD);
   assign eng_halt     = (state_q == HALT);
   assign eng_key      = key_q;
   assign busy         = !(state_q == IDLE || state_q == RUN);
   assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_aes_host_driver.sv
// Bench for aes_host_driver: stub pipelined engine, scoreboard of expected responses,
// directed vectors plus randomized job streams.
module tb_aes_host_driver;
   import aes_host_pkg::*;

   localparam int ENG_LAT = 12;
   localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] FIPS_PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
   localparam logic [127:0] FIPS_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;

   logic clk = 1'b0;
   logic rst, key_valid, key_ready, req_valid, req_ready, rsp_valid, rsp_ready;
   logic eng_set_key, eng_halt, busy, err_overflow;
   logic [127:0] key_in, req_data, rsp_data, eng_state, eng_key, eng_out;
   job_t req_type, rsp_type, eng_in_type, eng_out_type;

   always #5 clk = ~clk;

   aes_host_driver #(.FIFO_DEPTH(16), .WARM_CYCLES(12)) dut (
      .clk(clk), .rst(rst),
      .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type), .rsp_data(rsp_data),
      .eng_in_type(eng_in_type), .eng_set_key(eng_set_key), .eng_halt(eng_halt),
      .eng_state(eng_state), .eng_key(eng_key), .eng_out(eng_out), .eng_out_type(eng_out_type),
      .busy(busy), .err_overflow(err_overflow)
   );

   // Toy invertible cipher standing in for AES, with the FIPS-197 pair special-cased.
   function automatic logic [127:0] cipher(input job_t t, input logic [127:0] d, input logic [127:0] k);
      logic [127:0] x;
      if (k == FIPS_KEY && t == ENCRYPT && d == FIPS_PT) return FIPS_CT;
      if (k == FIPS_KEY && t == DECRYPT && d == FIPS_CT) return FIPS_PT;
      if (t == ENCRYPT) begin
         x = {d[114:0], d[127:115]};
         return x ^ k;
      end
      x = d ^ k;
      return {x[12:0], x[127:13]};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   typedef struct packed {job_t t; logic [127:0] d;} eres_t;
   eres_t        pipe [ENG_LAT];
   logic [127:0] ekey;
   logic         eng_clr;

   always @(posedge clk) begin
      if (eng_clr || eng_halt) begin
         for (int i = 0; i < ENG_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{t: eng_in_type,
                      d: (eng_in_type == INVALID) ? '0 : cipher(eng_in_type, eng_state, ekey)};
         for (int i = 1; i < ENG_LAT; i++) pipe[i] <= pipe[i-1];
      end
      if (eng_clr) ekey <= '0;
      else if (eng_set_key) ekey <= eng_key;
   end
   assign eng_out_type = pipe[ENG_LAT-1].t;
   assign eng_out      = pipe[ENG_LAT-1].d;

   int n_tests = 0;
   int n_fail  = 0;
   int rsp_seen = 0;
   int rdy_mode = 1;
   logic [127:0] model_key = '0;
   eres_t sb [$];

   typedef struct {
      job_t         jt;
      logic [127:0] data;
      bit           exp_rsp;
      job_t         exp_type;
      logic [127:0] exp_data;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      eres_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (key_valid && key_ready) model_key = key_in;
            if (req_valid && req_ready && req_type != INVALID)
               sb.push_back('{t: req_type, d: cipher(req_type, req_data, model_key)});
            if (rsp_valid && rsp_ready) begin
               rsp_seen++;
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_rsp: got type %0d data %h, expected no response",
                           rsp_type, rsp_data);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_type", 128'(rsp_type), 128'(e.t));
                  chk("rsp_data", rsp_data, e.d);
               end
            end
         end
      end
   endtask

   task automatic rdy_drv();
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   endtask

   task automatic send_job(input job_t t, input logic [127:0] d);
      int guard = 0;
      bit done = 0;
      req_valid = 1'b1;
      req_type  = t;
      req_data  = d;
      while (!done && guard < 300) begin
         @(negedge clk);
         guard++;
         if (req_ready) done = 1;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_job: req_ready never high, got timeout expected handshake");
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      int guard = 0;
      bit done = 0;
      key_valid = 1'b1;
      key_in    = k;
      while (!done && guard < 300) begin
         @(negedge clk);
         guard++;
         if (key_ready) done = 1;
         @(posedge clk);
         #1;
      end
      key_valid = 1'b0;
      chk("key_handshake", 128'(done), 128'(1));
   endtask

   task automatic wait_run();
      int guard = 0;
      while (busy && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("wait_run_busy", 128'(busy), 128'(0));
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 400) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("drain_left", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      int lat, base, accepted, cyc, halt_cnt, sk_cnt, halt_at, sk_at, rsp_at_halt, r;
      bit hs;
      job_t idle_type, t;
      logic [127:0] k2;

      rst = 1'b1; eng_clr = 1'b1;
      key_valid = 0; key_in = '0; req_valid = 0; req_type = INVALID; req_data = '0;
      rsp_ready = 1'b0;

      vecs[0] = '{jt: ENCRYPT, data: FIPS_PT, exp_rsp: 1, exp_type: ENCRYPT, exp_data: FIPS_CT};
      vecs[1] = '{jt: DECRYPT, data: FIPS_CT, exp_rsp: 1, exp_type: DECRYPT, exp_data: FIPS_PT};
      vecs[2] = '{jt: INVALID, data: FIPS_PT, exp_rsp: 0, exp_type: INVALID, exp_data: '0};
      vecs[3] = '{jt: ENCRYPT, data: FIPS_PT, exp_rsp: 1, exp_type: ENCRYPT, exp_data: FIPS_CT};

      fork
         monitor();
         rdy_drv();
         begin
            #2_000_000;
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_key_ready", 128'(key_ready), 128'(0));
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_rsp_type", 128'(rsp_type), 128'(INVALID));
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_eng_in_type", 128'(eng_in_type), 128'(INVALID));
      chk("rst_eng_set_key", 128'(eng_set_key), 128'(0));
      chk("rst_eng_halt", 128'(eng_halt), 128'(0));
      chk("rst_eng_state", eng_state, '0);
      chk("rst_eng_key", eng_key, '0);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_err_overflow", 128'(err_overflow), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      eng_clr = 1'b0;
      #1;
      chk("post_rst_key_ready", 128'(key_ready), 128'(1));

      // Bring-up and directed vectors
      load_key(FIPS_KEY);
      chk("load_busy", 128'(busy), 128'(1));
      wait_run();
      chk("eng_key", eng_key, FIPS_KEY);
      for (int v = 0; v < 4; v++) begin
         base = rsp_seen;
         send_job(vecs[v].jt, vecs[v].data);
         chk($sformatf("v%0d_eng_in_type", v), 128'(eng_in_type), 128'(vecs[v].jt));
         chk($sformatf("v%0d_eng_state", v), eng_state,
             (vecs[v].jt == INVALID) ? 128'h0 : vecs[v].data);
         lat = 0;
         idle_type = INVALID;
         while (!rsp_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) idle_type = eng_in_type;
         end
         chk($sformatf("v%0d_idle_in_type", v), 128'(idle_type), 128'(INVALID));
         if (vecs[v].exp_rsp) begin
            chk($sformatf("v%0d_latency", v), 128'(lat), 128'(13));
            chk($sformatf("v%0d_type", v), 128'(rsp_type), 128'(vecs[v].exp_type));
            chk($sformatf("v%0d_data", v), rsp_data, vecs[v].exp_data);
            @(posedge clk);
            #1;
         end else begin
            chk($sformatf("v%0d_no_rsp", v), 128'(rsp_seen - base), 128'(0));
         end
      end
      wait_drain();

      // Key/request collision in RUN
      key_valid = 1'b1; key_in = FIPS_KEY;
      req_valid = 1'b1; req_type = ENCRYPT; req_data = rnd128();
      #1;
      chk("collide_req_ready", 128'(req_ready), 128'(0));
      chk("collide_key_ready", 128'(key_ready), 128'(1));
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      req_valid = 1'b0;
      chk("collide_busy", 128'(busy), 128'(1));
      chk("collide_no_issue", 128'(eng_in_type), 128'(INVALID));
      wait_run();

      // Rekey with five jobs in flight
      k2 = rnd128();
      base = rsp_seen;
      for (int j = 0; j < 5; j++) send_job(ENCRYPT, rnd128());
      load_key(k2);
      cyc = 0; halt_cnt = 0; sk_cnt = 0; halt_at = -1; sk_at = -1; rsp_at_halt = -1;
      while ((busy || cyc == 0) && cyc < 200) begin
         if (eng_halt) begin
            halt_cnt++;
            halt_at = cyc;
            rsp_at_halt = rsp_seen - base;
         end
         if (eng_set_key) begin
            sk_cnt++;
            sk_at = cyc;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("rekey_busy", 128'(busy), 128'(0));
      chk("rekey_halt_pulses", 128'(halt_cnt), 128'(1));
      chk("rekey_setkey_pulses", 128'(sk_cnt), 128'(1));
      chk("rekey_setkey_after_halt", 128'(sk_at), 128'(halt_at + 1));
      chk("rekey_old_rsps", 128'(rsp_at_halt), 128'(5));
      chk("rekey_eng_key", eng_key, k2);
      send_job(ENCRYPT, rnd128());
      wait_drain();

      // Backpressure: 20 jobs, responses held back
      rdy_mode = 0;
      @(posedge clk);
      #1;
      base = rsp_seen;
      accepted = 0;
      req_valid = 1'b1; req_type = ENCRYPT; req_data = rnd128();
      for (int c = 0; c < 40 && accepted < 20; c++) begin
         @(negedge clk);
         hs = req_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            accepted++;
            req_data = rnd128();
         end
      end
      chk("bp_accepted", 128'(accepted), 128'(16));
      chk("bp_req_ready", 128'(req_ready), 128'(0));
      chk("bp_rsp_valid", 128'(rsp_valid), 128'(1));
      chk("bp_overflow", 128'(err_overflow), 128'(0));
      rdy_mode = 1;
      for (int c = 0; c < 300 && accepted < 20; c++) begin
         @(negedge clk);
         hs = req_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            accepted++;
            req_data = rnd128();
         end
      end
      req_valid = 1'b0;
      chk("bp_total_accepted", 128'(accepted), 128'(20));
      wait_drain();
      chk("bp_rsp_count", 128'(rsp_seen - base), 128'(20));

      // Randomized stream with random response backpressure
      rdy_mode = 2;
      for (int i = 0; i < 100; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         if (i == 50) begin
            load_key(rnd128());
            wait_run();
         end
         r = $urandom_range(0, 9);
         t = (r == 0) ? INVALID : ((r < 6) ? ENCRYPT : DECRYPT);
         send_job(t, rnd128());
      end
      rdy_mode = 1;
      wait_drain();
      chk("rand_overflow", 128'(err_overflow), 128'(0));

      // Reset with queued and in-flight results
      rdy_mode = 0;
      for (int j = 0; j < 3; j++) send_job(DECRYPT, rnd128());
      repeat (16) @(posedge clk);
      #1;
      chk("prerst_rsp_valid", 128'(rsp_valid), 128'(1));
      for (int j = 0; j < 8; j++) send_job(ENCRYPT, rnd128());
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("midrst_rsp_type", 128'(rsp_type), 128'(INVALID));
      chk("midrst_rsp_data", rsp_data, '0);
      chk("midrst_busy", 128'(busy), 128'(0));
      chk("midrst_key_ready", 128'(key_ready), 128'(0));
      chk("midrst_req_ready", 128'(req_ready), 128'(0));
      chk("midrst_eng_in_type", 128'(eng_in_type), 128'(INVALID));
      chk("midrst_eng_key", eng_key, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rdy_mode = 1;
      #1;
      chk("postrst_key_ready", 128'(key_ready), 128'(1));
      chk("postrst_busy", 128'(busy), 128'(0));
      base = rsp_seen;
      repeat (30) @(posedge clk);
      #1;
      chk("postrst_stale_rsps", 128'(rsp_seen - base), 128'(0));

      // Recovery after reset
      load_key(FIPS_KEY);
      wait_run();
      base = rsp_seen;
      send_job(ENCRYPT, FIPS_PT);
      wait_drain();
      chk("recover_rsp_count", 128'(rsp_seen - base), 128'(1));
      chk("final_overflow", 128'(err_overflow), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_host_driver.md
AES_HOST_DRIVER -- requirements
Module: aes_host_driver

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 16, which sets the response FIFO entries; it is a power of 2 and at least 12.
REQ-002 The module SHALL have parameter WARM_CYCLES, default 12, which sets the wait cycles for engine key expansion after the priming job.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have ports key_valid (in, 1), key_ready (out, 1) and key_in (in, 128): the host key-load handshake.
REQ-006 The module SHALL have ports req_valid (in, 1), req_ready (out, 1), req_type (in, job_t) and req_data (in, 128): the host job handshake.
REQ-007 The module SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_type (out, job_t) and rsp_data (out, 128): the host result handshake.
REQ-008 The module SHALL have engine-side outputs eng_in_type (job_t), eng_set_key (1), eng_halt (1), eng_state (128) and eng_key (128), which drive the AES engine inputs.
REQ-009 The module SHALL have engine-side inputs eng_out (128) and eng_out_type (job_t), which come from the AES engine outputs.
REQ-010 The module SHALL have status outputs busy (1), which is high in any state other than IDLE or RUN, and err_overflow (1), which is sticky.

Function
REQ-011 The FSM states SHALL be: IDLE, LOAD, PRIME, WARM, RUN, DRAIN, HALT.
REQ-012 key_ready SHALL be 1 in IDLE and in RUN, and 0 otherwise.
REQ-013 On a key handshake, key_in SHALL latch into key_q; from IDLE go to LOAD, from RUN go to DRAIN.
REQ-014 LOAD SHALL assert eng_set_key for exactly 1 cycle, then go to PRIME.
REQ-015 PRIME SHALL drive eng_in_type=ENCRYPT and eng_state=0 for 1 cycle to trigger engine key expansion, then:
- set discard_pend=1;
- increment inflight;
- go to WARM.
REQ-016 WARM SHALL count WARM_CYCLES cycles, then go to RUN.
REQ-017 DRAIN SHALL issue no jobs and go to HALT once inflight==0 and discard_pend==0.
REQ-018 HALT SHALL assert eng_halt for exactly 1 cycle, then go to LOAD.
REQ-019 eng_key SHALL equal key_q at all times.
REQ-020 req_ready SHALL equal (state==RUN) && !key_valid && (fifo_count + inflight < FIFO_DEPTH).
REQ-021 When key_valid and req_valid are both high in RUN, the key SHALL win.
REQ-022 Engine-side outputs SHALL be registered: a job handshake at edge k drives eng_in_type=req_type and eng_state=req_data during cycle k+1.
REQ-023 In every cycle without an issued job, eng_in_type SHALL be INVALID and eng_state SHALL be 0.
REQ-024 A handshaked job with req_type==INVALID SHALL be consumed silently: it is not issued, not counted, and produces no response.
REQ-025 inflight SHALL be 5 bits wide and:
- increment on issue;
- decrement on each cycle with eng_out_type!=INVALID;
- remain unchanged on a simultaneous increment and decrement.
REQ-026 The first eng_out_type!=INVALID result while discard_pend==1 SHALL be dropped and SHALL clear discard_pend.
REQ-027 Every other non-INVALID result SHALL be written to the FIFO as {eng_out_type, eng_out} at that edge.
REQ-028 The response FIFO SHALL be first-in first-out with rsp_valid = !empty and rsp_type/rsp_data = head entry.
REQ-029 The FIFO SHALL pop on rsp_valid && rsp_ready, and a simultaneous push and pop SHALL be legal when full or empty.
REQ-030 The FIFO SHALL keep fifo_count with 1 extra bit and wrap its pointers modulo FIFO_DEPTH.
REQ-031 A push while the FIFO is full and not popping SHALL drop the data and set err_overflow, which holds until reset.
REQ-032 The engine result order SHALL equal the issue order; no reordering logic is present.

Reset
REQ-033 While rst is high, the module SHALL hold: state=IDLE, key_q=0, inflight=0, discard_pend=0, FIFO empty, WARM counter=0.
REQ-034 While rst is high, the outputs SHALL be: key_ready=0, req_ready=0, rsp_valid=0, rsp_type=INVALID, rsp_data=0.
REQ-035 While rst is high, the engine-side and status outputs SHALL be: eng_in_type=INVALID, eng_set_key=0, eng_halt=0, eng_state=0, eng_key=0, busy=0, err_overflow=0.
REQ-036 A reset asserted mid-operation SHALL discard all in-flight and queued results immediately, and results arriving after reset release SHALL NOT be pushed unless inflight>0.

Verification
REQ-037 Bring-up check: key 2b7e1516_28aed2a6_abf71588_09cf4f3c then FIPS-197 plaintext 3243f6a8_885a308d_313198a2_e0370734 ENCRYPT -> one response 3925841d_02dc09fb_dc118597_196a0b32, type ENCRYPT; the priming result is absent.
REQ-038 Round-trip check: DECRYPT of 3925841d_02dc09fb_dc118597_196a0b32 under the same key -> 3243f6a8_885a308d_313198a2_e0370734, 13 cycles after its handshake edge with rsp_ready=1.
REQ-039 Backpressure check: rsp_ready=0 while streaming 20 ENCRYPT jobs -> req_ready drops after 16 accepted, err_overflow stays 0, and after release all 20 responses return in order.
REQ-040 Rekey check: key_valid during RUN with 5 jobs in flight -> 5 old-key results delivered, then eng_halt pulses 1 cycle, eng_set_key pulses 1 cycle, and the next job uses the new key.
REQ-041 Collision and invalid-job check: key_valid and req_valid in the same RUN cycle -> key accepted, req_ready=0; a req_type=INVALID job -> consumed with no response.
REQ-042 Reset check: rst asserted with 8 jobs in flight -> rsp_valid=0 and inflight=0 at once; after release, state is IDLE and key_ready=1.
